entropy_collector: RTL and testbench
====================================

Name: entropy_collector

Overview:
- Sits directly upstream of the post-processing accumulator in the TRNG datapath.
- Synchronises the raw ring-oscillator bit and samples it on a sample strobe.
- Debiases the samples with a von Neumann corrector and packs the accepted bits into WIDTH-bit words.
- Emits each word with a one-cycle valid pulse; its output pair drives the accumulator's valid/data inputs.
- A repetition-count health test latches a sticky failure flag; while it is set, output is suppressed.

Parameters:
- WIDTH, 32: output word width in bits.
- SYNC_STAGES, 2: number of synchroniser flops on raw_bit (at least 2).
- RCT_LIMIT, 32: run length of identical raw samples that trips the health test (range 2..255).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- raw_bit  input  1  asynchronous raw entropy bit from the ring-oscillator array.
- sample_en  input  1  one-cycle sample strobe; the synchronised bit is sampled on cycles where it is high.
- valid_out  output  1  one-cycle pulse marking a new word on random_out.
- random_out  output  WIDTH  packed debiased word; holds its value between pulses.
- rct_fail  output  1  sticky health-test failure flag.

Behaviour:
- Reset:
  - Synchroniser flops, shift register, bit counter, run counter, FSM state and all outputs clear to 0.
  - FSM state is FIRST; have_last clears to 0.
  - Reset mid-word discards the partial word.
- Synchroniser: raw_bit passes through a SYNC_STAGES flop chain; the last stage is s_bit. Latency is SYNC_STAGES cycles.
- Sampling: only cycles with sample_en=1 have any effect. With sample_en=0, all state holds and valid_out=0.
- Von Neumann FSM (states FIRST, SECOND), on sample_en:
  - FIRST: b0 <= s_bit; go to SECOND.
  - SECOND: if s_bit != b0, accept bit b0 (pair 10 yields 1, pair 01 yields 0). Pairs 00 and 11 are discarded. Always return to FIRST.
- Packing, on an accepted bit:
  - sr <= {sr[WIDTH-2:0], b0}; the first accepted bit ends up at the MSB.
  - bit_cnt (range 0..WIDTH-1) increments.
  - When bit_cnt == WIDTH-1:
    - random_out <= {sr[WIDTH-2:0], b0}
    - valid_out <= 1 for exactly one cycle
    - bit_cnt <= 0
  - valid_out therefore rises the cycle after the sample_en that completes the WIDTH-th accepted pair.
- Repetition count test, on every sample_en using s_bit:
  - If have_last=0: run=1, last=s_bit, have_last=1.
  - Else if s_bit == last: run increments, saturating at RCT_LIMIT.
  - Else: run=1, last=s_bit.
  - When the new run value equals RCT_LIMIT, rct_fail <= 1.
- Failure handling:
  - rct_fail stays set until rst.
  - While it is set, the FSM, packer and counters freeze; valid_out stays 0 and random_out holds its last value.
  - The partial word is discarded.
- Simultaneous events: if the failing sample is the same sample that would complete a word, the failure wins. No valid_out is produced and random_out is not updated.
- Back-to-back sample_en on every cycle must be supported. Minimum word spacing is 2*WIDTH cycles.

Test Plan:
1. Reset: hold rst 3 cycles with raw_bit toggling -> valid_out=0, random_out=0x00000000, rct_fail=0. No pulse for 10 cycles after release with sample_en=0.
2. Stream 1,0 repeated 32 times with sample_en every cycle -> exactly one valid_out pulse, random_out=0xFFFFFFFF, and the pulse arrives 1 cycle after the 64th sample. Then stream 0,1 x32 -> random_out=0x00000000.
3. Alternate pairs 10,01 for 32 pairs -> random_out=0xAAAAAAAA. Then insert pairs 00 and 11 between every good pair -> same word, with the pulse delayed by 64 samples; rct_fail stays 0.
4. Gapped strobe: sample_en every 5th cycle with the test-2 data -> same word 0xFFFFFFFF, exactly one pulse, and no state change on idle cycles.
5. Health test: after a partial word (10 accepted bits), feed 32 consecutive 1 samples -> rct_fail=1 on the cycle after the 32st... 32nd such sample. Subsequent good pairs produce no valid_out, random_out is unchanged, and only rst clears rct_fail.
6. Reset mid-word: accept 20 bits, assert rst for 1 cycle, then stream 10 x32 -> one pulse with random_out=0xFFFFFFFF, with no residue from the pre-reset bits.

Source files
------------

// File: rtl/entropy_collector.sv
// entropy_collector: samples a synchronised ring-oscillator bit on a strobe and
// debiases the samples with a von Neumann corrector. Accepted bits are packed
// into WIDTH-bit words, first bit at the MSB. A repetition-count health test
// latches a sticky failure, which freezes collection until reset.
module entropy_collector #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int RCT_LIMIT   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             raw_bit,
   input  logic             sample_en,
   output logic             valid_out,
   output logic [WIDTH-1:0] random_out,
   output logic             rct_fail
);

   localparam int               CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
   localparam logic [7:0]       LIM     = 8'(RCT_LIMIT);

   typedef enum logic {
      ST_FIRST  = 1'b0,
      ST_SECOND = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s_bit;
   state_t                 r_state;
   state_t                 w_state_next;
   logic                   r_b0;
   logic                   w_accept;
   logic [WIDTH-2:0]       r_sr;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [7:0]             r_run;
   logic [7:0]             w_run_next;
   logic                   r_last;
   logic                   r_have_last;
   logic                   w_live;
   logic                   w_trip;
   logic                   w_step;

   // Synchroniser chain for the asynchronous raw bit; the last stage is s_bit.
   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], raw_bit};
   end

   assign w_s_bit = r_sync[SYNC_STAGES-1];

   // A sample counts only on the strobe and only while the health test is clean.
   // The sample that trips the test is consumed by the test alone, so a word it
   // would have completed is never emitted.
   assign w_live = sample_en & ~rct_fail;
   assign w_trip = w_live & (w_run_next == LIM);
   assign w_step = w_live & ~w_trip;

   // Run length that this sample would produce, saturating at the limit.
   always_comb begin
      w_run_next = 8'd1;
      if (r_have_last && (w_s_bit == r_last)) begin
         w_run_next = (r_run == LIM) ? LIM : r_run + 8'd1;
      end
   end

   // Repetition-count state and the sticky failure flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run       <= 8'd0;
         r_last      <= 1'b0;
         r_have_last <= 1'b0;
         rct_fail    <= 1'b0;
      end else if (w_live) begin
         r_run       <= w_run_next;
         r_last      <= w_s_bit;
         r_have_last <= 1'b1;
         if (w_trip) rct_fail <= 1'b1;
      end
   end

   // Von Neumann pair FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_FIRST;
      else     r_state <= w_state_next;
   end

   // Von Neumann next state; a pair of differing samples yields its first bit.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      if (w_step) begin
         case (r_state)
            ST_FIRST:  w_state_next = ST_SECOND;
            ST_SECOND: begin
               w_state_next = ST_FIRST;
               w_accept     = (w_s_bit != r_b0);
            end
            default:   w_state_next = ST_FIRST;
         endcase
      end
   end

   // Capture the first sample of each pair.
   always_ff @(posedge clk) begin
      if (rst)                              r_b0 <= 1'b0;
      else if (w_step && r_state == ST_FIRST) r_b0 <= w_s_bit;
   end

   // Pack accepted bits MSB-first and publish each full word with a single pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         valid_out  <= 1'b0;
         random_out <= '0;
      end else begin
         valid_out <= 1'b0;
         if (w_trip) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
         end else if (w_accept) begin
            r_sr <= {r_sr[WIDTH-3:0], r_b0};
            if (r_bit_cnt == CNT_MAX) begin
               random_out <= {r_sr, r_b0};
               valid_out  <= 1'b1;
               r_bit_cnt  <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_entropy_collector.sv
// Bench for entropy_collector: directed scenarios plus randomized streams,
// compared against a sample-level model of the debias / pack / health rules.
module tb_entropy_collector;

   localparam int W   = 32;
   localparam int LIM = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         raw_bit = 1'b0;
   logic         sample_en = 1'b0;
   logic         valid_out;
   logic [W-1:0] random_out;
   logic         rct_fail;

   always #5 clk = ~clk;

   entropy_collector #(.WIDTH(W), .SYNC_STAGES(2), .RCT_LIMIT(LIM)) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_bit    (raw_bit),
      .sample_en  (sample_en),
      .valid_out  (valid_out),
      .random_out (random_out),
      .rct_fail   (rct_fail)
   );

   int checks = 0;
   int errors = 0;

   // two-deep delay so each strobe lines up with the bit it should sample
   bit pe0, pe1, pb0, pb1;

   // reference model state
   bit           m_open, m_first, m_have, m_last, m_fail;
   int           m_run;
   bit           m_acc[$];
   logic [W-1:0] m_word;

   // observation tallies
   int n_samp, obs_pulses, exp_pulses, samp_at_pulse, fail_samp, vmis, wmis, fmis;

   task automatic model_reset();
      m_open = 0; m_first = 0; m_have = 0; m_last = 0; m_fail = 0;
      m_run = 0; m_acc.delete(); m_word = '0;
   endtask

   task automatic clear_obs();
      n_samp = 0; obs_pulses = 0; exp_pulses = 0; samp_at_pulse = -1;
      fail_samp = -1; vmis = 0; wmis = 0; fmis = 0;
   endtask

   task automatic model_sample(input bit b, output bit ev);
      logic [W-1:0] w;
      ev = 0;
      if (m_fail) return;
      if (!m_have || b != m_last) begin
         m_run = 1; m_last = b; m_have = 1;
      end else if (m_run < LIM) begin
         m_run++;
      end
      if (m_run == LIM) begin
         m_fail = 1;
         m_acc.delete();
         return;
      end
      if (!m_open) begin
         m_first = b; m_open = 1;
      end else begin
         m_open = 0;
         if (b != m_first) m_acc.push_back(m_first);
         if (m_acc.size() == W) begin
            w = '0;
            foreach (m_acc[i]) w = {w[W-2:0], m_acc[i]};
            m_word = w; ev = 1;
            m_acc.delete();
         end
      end
   endtask

   task automatic drive_cycle(input bit b, input bit en);
      bit cur_b, cur_e, ev;
      @(negedge clk);
      cur_e = pe1; cur_b = pb1;
      sample_en = cur_e; raw_bit = b;
      pe1 = pe0; pb1 = pb0; pe0 = en; pb0 = b;
      @(posedge clk); #1;
      ev = 0;
      if (cur_e) begin
         n_samp++;
         model_sample(cur_b, ev);
      end
      if (ev) exp_pulses++;
      if (valid_out === 1'b1) begin obs_pulses++; samp_at_pulse = n_samp; end
      if (rct_fail === 1'b1 && fail_samp < 0) fail_samp = n_samp;
      if (valid_out !== ev) vmis++;
      if (random_out !== m_word) wmis++;
      if (rct_fail !== m_fail) fmis++;
   endtask

   task automatic flush();
      drive_cycle(1'($urandom_range(0, 1)), 1'b0);
      drive_cycle(1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic send_pair(input bit a, input bit b);
      drive_cycle(a, 1'b1);
      drive_cycle(b, 1'b1);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1; sample_en = 1'b0;
      pe0 = 0; pe1 = 0; pb0 = 0; pb1 = 0;
      repeat (n) begin
         raw_bit = ~raw_bit;
         @(negedge clk);
      end
      rst = 1'b0;
      model_reset();
      clear_obs();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; sample_en = 1'b0;
      pe0 = 0; pe1 = 0; pb0 = 0; pb1 = 0;
      repeat (3) begin
         raw_bit = ~raw_bit;
         @(negedge clk);
      end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_out); end
      checks++; if (random_out !== 32'h0) begin errors++; $display("FAIL rst_word got %h want 00000000", random_out); end
      checks++; if (rct_fail !== 1'b0) begin errors++; $display("FAIL rst_fail got %b want 0", rct_fail); end
      rst = 1'b0;
      model_reset(); clear_obs();
      repeat (10) drive_cycle(1'($urandom_range(0, 1)), 1'b0);
      checks++; if (obs_pulses !== 0) begin errors++; $display("FAIL rst_idle_pulses got %0d want 0", obs_pulses); end
      $display("test_reset: done");
   endtask

   task automatic test_stream();
      clear_obs();
      repeat (32) send_pair(1'b1, 1'b0);
      flush();
      checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL s10_pulses got %0d want 1", obs_pulses); end
      checks++; if (random_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL s10_word got %h want FFFFFFFF", random_out); end
      checks++; if (samp_at_pulse !== 64) begin errors++; $display("FAIL s10_latency pulse after sample %0d want 64", samp_at_pulse); end
      checks++; if (vmis !== 0) begin errors++; $display("FAIL s10_valid_timing mismatching cycles %0d want 0", vmis); end
      $display("test_stream 10: pulses=%0d word=%h", obs_pulses, random_out);
      clear_obs();
      repeat (32) send_pair(1'b0, 1'b1);
      flush();
      checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL s01_pulses got %0d want 1", obs_pulses); end
      checks++; if (random_out !== 32'h0) begin errors++; $display("FAIL s01_word got %h want 00000000", random_out); end
      $display("test_stream 01: pulses=%0d word=%h", obs_pulses, random_out);
   endtask

   task automatic test_pairs();
      clear_obs();
      repeat (16) begin send_pair(1'b1, 1'b0); send_pair(1'b0, 1'b1); end
      flush();
      checks++; if (random_out !== 32'hAAAAAAAA) begin errors++; $display("FAIL alt_word got %h want AAAAAAAA", random_out); end
      checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL alt_pulses got %0d want 1", obs_pulses); end
      $display("test_pairs alt: word=%h", random_out);
      clear_obs();
      for (int k = 0; k < 32; k++) begin
         if (k % 2 == 0) send_pair(1'b0, 1'b0); else send_pair(1'b1, 1'b1);
         if (k % 2 == 0) send_pair(1'b1, 1'b0); else send_pair(1'b0, 1'b1);
      end
      flush();
      checks++; if (random_out !== 32'hAAAAAAAA) begin errors++; $display("FAIL junk_word got %h want AAAAAAAA", random_out); end
      checks++; if (samp_at_pulse !== 128) begin errors++; $display("FAIL junk_latency pulse after sample %0d want 128", samp_at_pulse); end
      checks++; if (rct_fail !== 1'b0) begin errors++; $display("FAIL junk_rct got %b want 0", rct_fail); end
      $display("test_pairs junk: word=%h at sample %0d", random_out, samp_at_pulse);
   endtask

   task automatic test_gapped();
      bit d;
      do_reset(1);
      for (int k = 0; k < 64; k++) begin
         d = (k % 2 == 0);
         drive_cycle(d, 1'b1);
         repeat (4) drive_cycle(1'($urandom_range(0, 1)), 1'b0);
      end
      flush();
      checks++; if (random_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL gap_word got %h want FFFFFFFF", random_out); end
      checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL gap_pulses got %0d want 1", obs_pulses); end
      checks++; if (samp_at_pulse !== 64) begin errors++; $display("FAIL gap_latency pulse after sample %0d want 64", samp_at_pulse); end
      checks++; if (vmis !== 0) begin errors++; $display("FAIL gap_valid_timing mismatching cycles %0d want 0", vmis); end
      $display("test_gapped: word=%h pulses=%0d", random_out, obs_pulses);
   endtask

   task automatic test_health();
      bit a;
      clear_obs();
      for (int k = 0; k < 10; k++) begin
         a = (k == 9) ? 1'b1 : 1'($urandom_range(0, 1));
         send_pair(a, ~a);
      end
      repeat (32) drive_cycle(1'b1, 1'b1);
      flush();
      checks++; if (fail_samp !== 52) begin errors++; $display("FAIL rct_trip flag rose after sample %0d want 52", fail_samp); end
      checks++; if (rct_fail !== 1'b1) begin errors++; $display("FAIL rct_set got %b want 1", rct_fail); end
      repeat (40) begin
         a = 1'($urandom_range(0, 1));
         send_pair(a, ~a);
      end
      flush();
      checks++; if (obs_pulses !== 0) begin errors++; $display("FAIL rct_suppress pulses %0d want 0", obs_pulses); end
      checks++; if (random_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL rct_hold word %h want FFFFFFFF", random_out); end
      checks++; if (rct_fail !== 1'b1) begin errors++; $display("FAIL rct_sticky got %b want 1", rct_fail); end
      do_reset(1);
      @(posedge clk); #1;
      checks++; if (rct_fail !== 1'b0) begin errors++; $display("FAIL rct_clear got %b want 0", rct_fail); end
      $display("test_health: trip at sample %0d", fail_samp);
   endtask

   task automatic test_midword_reset();
      bit a;
      do_reset(1);
      repeat (20) begin
         a = 1'($urandom_range(0, 1));
         send_pair(a, ~a);
      end
      do_reset(1);
      repeat (32) send_pair(1'b1, 1'b0);
      flush();
      checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL mid_pulses got %0d want 1", obs_pulses); end
      checks++; if (random_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mid_word got %h want FFFFFFFF", random_out); end
      checks++; if (samp_at_pulse !== 64) begin errors++; $display("FAIL mid_latency pulse after sample %0d want 64", samp_at_pulse); end
      $display("test_midword_reset: word=%h", random_out);
   endtask

   task automatic test_random(input bit biased, input int ncyc);
      bit b, e;
      do_reset(2);
      for (int k = 0; k < ncyc; k++) begin
         b = biased ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
         e = ($urandom_range(0, 3) != 0);
         drive_cycle(b, e);
      end
      flush();
      checks++; if (vmis !== 0) begin errors++; $display("FAIL rnd%0d_valid mismatching cycles %0d want 0", biased, vmis); end
      checks++; if (wmis !== 0) begin errors++; $display("FAIL rnd%0d_word mismatching cycles %0d want 0", biased, wmis); end
      checks++; if (fmis !== 0) begin errors++; $display("FAIL rnd%0d_rct mismatching cycles %0d want 0", biased, fmis); end
      checks++; if (obs_pulses !== exp_pulses) begin errors++; $display("FAIL rnd%0d_pulses got %0d want %0d", biased, obs_pulses, exp_pulses); end
      $display("test_random biased=%0d: pulses=%0d model=%0d rct=%b", biased, obs_pulses, exp_pulses, rct_fail);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_pairs();
      test_gapped();
      test_health();
      test_midword_reset();
      test_random(1'b0, 1200);
      test_random(1'b1, 1500);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
